// File: rtl/spi_xfer_ctrl.sv
// spi_xfer_ctrl: TX/RX FIFO-buffered word sequencer in front of an external SPI master.
// Build option SPI_XFER_CTRL_IRQ_EN adds a sticky end-of-burst irq with irq_clr.
//
// state        | meaning
// ST_IDLE      | cs_n high, waiting for enable with TX data and RX room
// ST_CS_SETUP  | cs_n low, SETUP_CYC cycles before the first word
// ST_LAUNCH    | TX head held in spi_data_in, spi_start high
// ST_WAIT_BUSY | spi_start held until the master reports busy
// ST_WAIT_DONE | master shifting, wait for busy low with new_data
// ST_CAPTURE   | push spi_data_out into RX, chain the next word or finish
// ST_CS_HOLD   | HOLD_CYC cycles before cs_n is released
module spi_xfer_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int SETUP_CYC  = 4,
  parameter int HOLD_CYC   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  tx_wr,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_full,
  output logic                  tx_empty,
  input  logic                  rx_rd,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_full,
  output logic                  rx_empty,
  output logic                  cs_n,
  output logic                  xfer_active,
  output logic                  spi_start,
  output logic [DATA_WIDTH-1:0] spi_data_in,
  input  logic [DATA_WIDTH-1:0] spi_data_out,
  input  logic                  spi_busy,
  input  logic                  spi_new_data
`ifdef SPI_XFER_CTRL_IRQ_EN
  ,
  output logic                  irq,
  input  logic                  irq_clr
`endif
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int AFULL_I = FIFO_DEPTH - 1;
  localparam logic [AW:0]   FULL_CNT  = FIFO_DEPTH[AW:0];
  localparam logic [AW:0]   AFULL_CNT = AFULL_I[AW:0];
  localparam logic [AW:0]   CNT_ONE   = CW'(1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [7:0]    SETUP_LD  = 8'(SETUP_CYC - 1);
  localparam logic [7:0]    HOLD_LD   = 8'(HOLD_CYC - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_CS_SETUP, ST_LAUNCH, ST_WAIT_BUSY, ST_WAIT_DONE, ST_CAPTURE, ST_CS_HOLD
  } state_t;

  state_t st, st_nxt;
  logic [7:0] tmr;
  logic rst_meta, rst_sync_n;
  logic tx_pop, tx_pop_ok, tx_push, rx_push, rx_push_ok, rx_pop_ok, rx_afull, can_launch;

  // Assert asynchronously, release two clocks later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_meta   <= 1'b0;
      rst_sync_n <= 1'b0;
    end else begin
      rst_meta   <= 1'b1;
      rst_sync_n <= rst_meta;
    end
  end

  logic [DATA_WIDTH-1:0] tx_mem [FIFO_DEPTH];
  logic [AW-1:0] tx_wp, tx_rp;
  logic [AW:0]   tx_cnt, tx_cnt_nxt;

  assign tx_push   = tx_wr & ~tx_full;
  assign tx_pop_ok = tx_pop & ~tx_empty;
  always_comb tx_cnt_nxt = tx_cnt + (tx_push ? CNT_ONE : '0) - (tx_pop_ok ? CNT_ONE : '0);

  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      tx_wp    <= '0;
      tx_rp    <= '0;
      tx_cnt   <= '0;
      tx_full  <= 1'b0;
      tx_empty <= 1'b1;
    end else begin
      if (tx_push)   tx_wp <= tx_wp + PTR_ONE;
      if (tx_pop_ok) tx_rp <= tx_rp + PTR_ONE;
      tx_cnt   <= tx_cnt_nxt;
      tx_full  <= (tx_cnt_nxt == FULL_CNT);
      tx_empty <= (tx_cnt_nxt == '0);
    end
  end

  always_ff @(posedge clk) if (tx_push) tx_mem[tx_wp] <= tx_data;

  logic [DATA_WIDTH-1:0] rx_mem [FIFO_DEPTH];
  logic [AW-1:0] rx_wp, rx_rp;
  logic [AW:0]   rx_cnt, rx_cnt_nxt;

  assign rx_push_ok = rx_push & ~rx_full;
  assign rx_pop_ok  = rx_rd & ~rx_empty;
  always_comb rx_cnt_nxt = rx_cnt + (rx_push_ok ? CNT_ONE : '0) - (rx_pop_ok ? CNT_ONE : '0);

  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      rx_wp    <= '0;
      rx_rp    <= '0;
      rx_cnt   <= '0;
      rx_full  <= 1'b0;
      rx_afull <= 1'b0;
      rx_empty <= 1'b1;
    end else begin
      if (rx_push_ok) rx_wp <= rx_wp + PTR_ONE;
      if (rx_pop_ok)  rx_rp <= rx_rp + PTR_ONE;
      rx_cnt   <= rx_cnt_nxt;
      rx_full  <= (rx_cnt_nxt == FULL_CNT);
      rx_afull <= (rx_cnt_nxt >= AFULL_CNT);
      rx_empty <= (rx_cnt_nxt == '0);
    end
  end

  always_ff @(posedge clk) if (rx_push_ok) rx_mem[rx_wp] <= spi_data_out;
  assign rx_data = rx_mem[rx_rp];

  assign can_launch = enable & ~tx_empty & ~rx_full;

  always_comb begin
    st_nxt  = st;
    tx_pop  = 1'b0;
    rx_push = 1'b0;
    case (st)
      ST_IDLE:      if (can_launch) st_nxt = ST_CS_SETUP;
      ST_CS_SETUP:  if (tmr == 8'd0) begin
                      st_nxt = ST_LAUNCH;
                      tx_pop = 1'b1;
                    end
      ST_LAUNCH:    st_nxt = ST_WAIT_BUSY;
      ST_WAIT_BUSY: if (spi_busy) st_nxt = ST_WAIT_DONE;
      ST_WAIT_DONE: if (!spi_busy && spi_new_data) st_nxt = ST_CAPTURE;
      ST_CAPTURE: begin
        rx_push = 1'b1;
        // The word being pushed may take the last RX slot; only chain if one more still fits.
        if (can_launch && !rx_afull) begin
          st_nxt = ST_LAUNCH;
          tx_pop = 1'b1;
        end else begin
          st_nxt = ST_CS_HOLD;
        end
      end
      ST_CS_HOLD:   if (tmr == 8'd0) st_nxt = ST_IDLE;
      default:      st_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      st          <= ST_IDLE;
      tmr         <= '0;
      spi_data_in <= '0;
    end else begin
      st <= st_nxt;
      if (st == ST_IDLE && st_nxt == ST_CS_SETUP)      tmr <= SETUP_LD;
      else if (st == ST_CAPTURE && st_nxt == ST_CS_HOLD) tmr <= HOLD_LD;
      else if (tmr != 8'd0)                            tmr <= tmr - 8'd1;
      // Loaded on entry to LAUNCH so the word is valid while spi_start is high.
      if (tx_pop_ok) spi_data_in <= tx_mem[tx_rp];
    end
  end

  assign cs_n        = (st == ST_IDLE);
  assign xfer_active = (st != ST_IDLE);
  assign spi_start   = (st == ST_LAUNCH) || (st == ST_WAIT_BUSY);

`ifdef SPI_XFER_CTRL_IRQ_EN
  logic irq_set;
  assign irq_set = (st == ST_CS_HOLD) && (tmr == 8'd0) && tx_empty;

  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) irq <= 1'b0;
    else             irq <= irq_set | (irq & ~irq_clr);
  end
`endif

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Directed bench for spi_xfer_ctrl with an echoing SPI master model and an RX scoreboard.
module tb_spi_xfer_ctrl;
  localparam int DW       = 32;
  localparam int SETUP    = 4;
  localparam int HOLD     = 4;
  localparam int XFER_CYC = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic enable = 1'b0, tx_wr = 1'b0, rx_rd = 1'b0;
  logic [DW-1:0] tx_data = '0;
  logic tx_full, tx_empty, rx_full, rx_empty, cs_n, xfer_active, spi_start;
  logic [DW-1:0] rx_data, spi_data_in, spi_data_out;
  logic spi_busy, spi_new_data;
`ifdef SPI_XFER_CTRL_IRQ_EN
  logic irq;
  logic irq_clr = 1'b0;
`endif

  spi_xfer_ctrl #(.DATA_WIDTH(DW), .FIFO_DEPTH(8), .SETUP_CYC(SETUP), .HOLD_CYC(HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .tx_wr(tx_wr), .tx_data(tx_data), .tx_full(tx_full), .tx_empty(tx_empty),
    .rx_rd(rx_rd), .rx_data(rx_data), .rx_full(rx_full), .rx_empty(rx_empty),
    .cs_n(cs_n), .xfer_active(xfer_active), .spi_start(spi_start),
    .spi_data_in(spi_data_in), .spi_data_out(spi_data_out),
    .spi_busy(spi_busy), .spi_new_data(spi_new_data)
`ifdef SPI_XFER_CTRL_IRQ_EN
    , .irq(irq), .irq_clr(irq_clr)
`endif
  );

  always #5 clk = ~clk;

  // Master model: optional delay before busy, fixed shift time, echoes the launched word.
  int m_dly = 0;
  int m_dcnt, m_cnt;
  logic [DW-1:0] m_word;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spi_busy <= 1'b0; spi_new_data <= 1'b0; spi_data_out <= '0;
      m_dcnt <= 0; m_cnt <= 0; m_word <= '0;
    end else if (spi_busy) begin
      if (m_cnt == 0) begin
        spi_busy <= 1'b0; spi_new_data <= 1'b1; spi_data_out <= m_word;
      end else m_cnt <= m_cnt - 1;
    end else if (spi_start) begin
      if (m_dcnt >= m_dly) begin
        spi_busy <= 1'b1; spi_new_data <= 1'b0; m_word <= spi_data_in;
        m_cnt <= XFER_CYC; m_dcnt <= 0;
      end else m_dcnt <= m_dcnt + 1;
    end else m_dcnt <= 0;
  end

  int start_edges = 0, start_hi = 0, cs_falls = 0;
  bit prev_start = 1'b0, prev_cs = 1'b1;
  always @(negedge clk) begin
    if (spi_start && !prev_start) start_edges++;
    if (spi_start) start_hi++;
    if (!cs_n && prev_cs) cs_falls++;
    prev_start = spi_start;
    prev_cs = cs_n;
  end

  int n_cmp = 0, n_mis = 0;
  logic [DW-1:0] exp_q[$];
  int b_st, b_cs, b_hi;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic snap();
    b_st = start_edges; b_cs = cs_falls; b_hi = start_hi;
  endtask

  task automatic push_tx(input logic [DW-1:0] w, input bit to_sb);
    tx_wr = 1'b1; tx_data = w;
    if (to_sb) exp_q.push_back(w);
    step(1);
    tx_wr = 1'b0;
  endtask

  task automatic pop_rx(input string tag);
    logic [DW-1:0] e;
    chk({tag, "_sb"}, 32'(exp_q.size() > 0), 1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    chk({tag, "_vld"}, rx_empty, 0);
    chk(tag, rx_data, e);
    rx_rd = 1'b1;
    step(1);
    rx_rd = 1'b0;
  endtask

  task automatic wait_rx(input string tag);
    int n = 0;
    while (rx_empty && n < 1000) begin step(1); n++; end
    chk({tag, "_tmo"}, rx_empty, 0);
  endtask

  task automatic wait_busy(input string tag);
    int n = 0;
    while (!spi_busy && n < 1000) begin step(1); n++; end
    chk({tag, "_tmo"}, spi_busy, 1);
  endtask

  task automatic wait_not_full(input string tag);
    int n = 0;
    while (tx_full && n < 1000) begin step(1); n++; end
    chk({tag, "_tmo"}, tx_full, 0);
  endtask

  task automatic wait_idle(input string tag, input int tgt);
    int n = 0;
    while (((start_edges - b_st) < tgt || xfer_active) && n < 3000) begin step(1); n++; end
    chk({tag, "_tmo"}, xfer_active, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired before end of sequence");
    $fatal(1);
  end

  initial begin
    #2 rst_n = 1'b0;
    step(3);
    chk("rst_cs_n", cs_n, 1);
    chk("rst_spi_start", spi_start, 0);
    chk("rst_spi_data_in", spi_data_in, 0);
    chk("rst_xfer_active", xfer_active, 0);
    chk("rst_tx_empty", tx_empty, 1);
    chk("rst_rx_empty", rx_empty, 1);
    chk("rst_tx_full", tx_full, 0);
    chk("rst_rx_full", rx_full, 0);
    rst_n = 1'b1;
    step(4);
`ifdef SPI_XFER_CTRL_IRQ_EN
    chk("irq_rst", irq, 0);
`endif

    // Single word with latency checks.
    enable = 1'b1;
    snap();
    push_tx(32'hA5A5_1234, 1'b1);
    chk("single_tx_empty_fall", tx_empty, 0);
    chk("single_cs_n_n1", cs_n, 1);
    step(1);
    chk("single_cs_n_low", cs_n, 0);
    chk("single_active", xfer_active, 1);
    step(SETUP - 1);
    chk("single_start_early", spi_start, 0);
    step(1);
    chk("single_start", spi_start, 1);
    chk("single_data_in", spi_data_in, 32'hA5A5_1234);
    wait_rx("single_cap");
    step(HOLD - 1);
    chk("single_cs_hold", cs_n, 0);
    step(1);
    chk("single_cs_rise", cs_n, 1);
    chk("single_starts", start_edges - b_st, 1);
    pop_rx("single_rx");

    // Burst of 8 preloaded words.
    enable = 1'b0;
    snap();
    for (int i = 0; i < 8; i++) push_tx(DW'(i), 1'b1);
    chk("burst_tx_full", tx_full, 1);
    chk("burst_cs_idle", cs_n, 1);
    enable = 1'b1;
    wait_idle("burst", 8);
    chk("burst_starts", start_edges - b_st, 8);
    chk("burst_cs_windows", cs_falls - b_cs, 1);
    chk("burst_rx_full", rx_full, 1);
    for (int i = 0; i < 8; i++) pop_rx("burst_rx");

    // RX back-pressure: 10 words, RX holds 8.
    enable = 1'b0;
    snap();
    for (int i = 0; i < 8; i++) push_tx(32'h100 + DW'(i), 1'b1);
    enable = 1'b1;
    wait_not_full("bp_room0");
    push_tx(32'h108, 1'b1);
    wait_not_full("bp_room1");
    push_tx(32'h109, 1'b1);
    wait_idle("bp_first", 8);
    chk("bp_starts8", start_edges - b_st, 8);
    chk("bp_rx_full", rx_full, 1);
    chk("bp_tx_left", tx_empty, 0);
    step(20);
    chk("bp_stalled", start_edges - b_st, 8);
    chk("bp_cs_high", cs_n, 1);
    pop_rx("bp_rx");
    pop_rx("bp_rx");
    wait_idle("bp_second", 10);
    chk("bp_starts10", start_edges - b_st, 10);
    chk("bp_cs_windows", cs_falls - b_cs, 2);
    chk("bp_tx_drained", tx_empty, 1);
    for (int i = 0; i < 8; i++) pop_rx("bp_rx");

    // Master that reports busy late.
    m_dly = 40;
    snap();
    push_tx(32'hBEEF_0001, 1'b1);
    wait_idle("late", 1);
    chk("late_starts", start_edges - b_st, 1);
    chk("late_start_held", 32'((start_hi - b_hi) >= 40), 1);
    pop_rx("late_rx");
    m_dly = 0;

    // Enable dropped mid-word: that word completes, the rest wait.
    enable = 1'b0;
    snap();
    for (int i = 0; i < 3; i++) push_tx(32'h200 + DW'(i), 1'b1);
    enable = 1'b1;
    wait_busy("endrop_busy");
    enable = 1'b0;
    wait_idle("endrop", 1);
    step(10);
    chk("endrop_starts", start_edges - b_st, 1);
    chk("endrop_tx_left", tx_empty, 0);
    pop_rx("endrop_rx");
    enable = 1'b1;
    wait_idle("endrop_flush", 3);
    pop_rx("endrop_rx");
    pop_rx("endrop_rx");

    // Reset during WAIT_DONE.
    push_tx(32'hDEAD_0000, 1'b0);
    wait_busy("rstmid_busy");
    step(2);
    rst_n = 1'b0;
    #1;
    chk("rstmid_cs_n", cs_n, 1);
    chk("rstmid_start", spi_start, 0);
    chk("rstmid_rx_empty", rx_empty, 1);
    chk("rstmid_active", xfer_active, 0);
    step(3);
    rst_n = 1'b1;
    step(20);
    chk("rstmid_no_push", rx_empty, 1);
    chk("rstmid_idle", cs_n, 1);

`ifdef SPI_XFER_CTRL_IRQ_EN
    chk("irq_after_rst", irq, 0);
    snap();
    for (int i = 0; i < 3; i++) push_tx(32'h300 + DW'(i), 1'b1);
    wait_idle("irq3", 3);
    chk("irq_set", irq, 1);
    for (int i = 0; i < 3; i++) pop_rx("irq_rx");
    irq_clr = 1'b1;
    step(1);
    irq_clr = 1'b0;
    chk("irq_cleared", irq, 0);
    push_tx(32'h3FF, 1'b1);
    wait_rx("irq_cap");
    step(HOLD - 1);
    irq_clr = 1'b1;
    step(1);
    irq_clr = 1'b0;
    chk("irq_set_wins", irq, 1);
    chk("irq_cs_rise", cs_n, 1);
    pop_rx("irq_rx");
`endif

    chk("sb_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
